// File: rtl/uart_pkg.sv
// Shared types and widths for the UART channel controller and its byte FIFOs.
package uart_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2
   } tx_ctrl_state_t;

endpackage

// File: rtl/uart_chan_ctrl_if.sv
// Host byte streams plus the parallel interface of one UART channel.
// The slave modport is the controller's view; master is the surrounding system.
interface uart_chan_ctrl_if;
   import uart_pkg::*;

   logic [BYTE_W-1:0] s_tx_data;
   logic              s_tx_valid;
   logic              s_tx_ready;
   logic [BYTE_W-1:0] m_rx_data;
   logic              m_rx_valid;
   logic              m_rx_ready;
   logic              chan_tx_start;
   logic [BYTE_W-1:0] chan_tx_data;
   logic              chan_tx_busy;
   logic [BYTE_W-1:0] chan_rx_data;
   logic              chan_rx_done;

   modport slave (
      input  s_tx_data, s_tx_valid, m_rx_ready,
      input  chan_tx_busy, chan_rx_data, chan_rx_done,
      output s_tx_ready, m_rx_data, m_rx_valid,
      output chan_tx_start, chan_tx_data
   );

   modport master (
      output s_tx_data, s_tx_valid, m_rx_ready,
      output chan_tx_busy, chan_rx_data, chan_rx_done,
      input  s_tx_ready, m_rx_data, m_rx_valid,
      input  chan_tx_start, chan_tx_data
   );

endinterface

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with show-ahead output. A push on a full FIFO is still taken when
// a pop happens in the same cycle, so the level stays at DEPTH.
module uart_byte_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [BYTE_W-1:0]        din,
   input  logic                     pop,
   output logic [BYTE_W-1:0]        dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [BYTE_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q;
   logic [AW-1:0]     rd_ptr_q;
   logic [LW-1:0]     level_q;
   logic              pop_ok;
   logic              push_ok;

   assign full    = (level_q == LW'(DEPTH));
   assign empty   = (level_q == '0);
   assign level   = level_q;
   assign dout    = mem_q[rd_ptr_q];
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);

   // Storage and pointers; storage is cleared so the head reads 0 out of reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // Occupancy moves only when exactly one of push/pop is taken.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         level_q <= '0;
      end else begin
         case ({push_ok, pop_ok})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

endmodule

// File: rtl/uart_chan_ctrl.sv
// Host-side controller for one UART channel: TX and RX byte FIFOs, a TX
// sequencer that hands one byte per frame to the channel, and a sticky RX
// overrun flag.
//
//   state | meaning
//   IDLE  | no frame owned; pop the next byte once the channel is not busy
//   START | chan_tx_start held until the channel reports busy
//   WAIT  | frame in progress; chan_tx_data held until busy drops
module uart_chan_ctrl
   import uart_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   uart_chan_ctrl_if.slave        bus,
   output logic [$clog2(DEPTH):0] tx_level,
   output logic [$clog2(DEPTH):0] rx_level,
   output logic                   rx_overrun,
   input  logic                   overrun_clr
);

   tx_ctrl_state_t    state_q;
   logic              chan_tx_start_q;
   logic [BYTE_W-1:0] chan_tx_data_q;
   logic              rx_overrun_q;
   logic              rx_overrun_d;

   logic              tx_push;
   logic              tx_pop;
   logic [BYTE_W-1:0] tx_dout;
   logic              tx_full;
   logic              tx_empty;

   logic              rx_pop;
   logic              rx_full;
   logic              rx_empty;
   logic              rx_drop;

   assign tx_push = bus.s_tx_valid && !tx_full;
   // The busy gate keeps a frame left over from before a reset from being
   // mistaken for the acknowledgement of a new start request.
   assign tx_pop  = (state_q == IDLE) && !tx_empty && !bus.chan_tx_busy;

   uart_byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (tx_push),
      .din   (bus.s_tx_data),
      .pop   (tx_pop),
      .dout  (tx_dout),
      .full  (tx_full),
      .empty (tx_empty),
      .level (tx_level)
   );

   assign rx_pop  = !rx_empty && bus.m_rx_ready;
   assign rx_drop = bus.chan_rx_done && rx_full && !rx_pop;

   uart_byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (bus.chan_rx_done),
      .din   (bus.chan_rx_data),
      .pop   (rx_pop),
      .dout  (bus.m_rx_data),
      .full  (rx_full),
      .empty (rx_empty),
      .level (rx_level)
   );

   assign bus.s_tx_ready    = !tx_full;
   assign bus.m_rx_valid    = !rx_empty;
   assign bus.chan_tx_start = chan_tx_start_q;
   assign bus.chan_tx_data  = chan_tx_data_q;
   assign rx_overrun        = rx_overrun_q;

   // TX sequencer: start is a level so a baud-tick-aligned transmitter cannot miss it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q         <= IDLE;
         chan_tx_start_q <= 1'b0;
         chan_tx_data_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (tx_pop) begin
                  chan_tx_data_q  <= tx_dout;
                  chan_tx_start_q <= 1'b1;
                  state_q         <= START;
               end
            end
            START: begin
               if (bus.chan_tx_busy) begin
                  chan_tx_start_q <= 1'b0;
                  state_q         <= WAIT;
               end
            end
            WAIT: begin
               if (!bus.chan_tx_busy) state_q <= IDLE;
            end
            default: begin
               chan_tx_start_q <= 1'b0;
               state_q         <= IDLE;
            end
         endcase
      end
   end

   // Overrun next state: a drop in the same cycle as a clear keeps the flag set.
   always_comb begin
      rx_overrun_d = rx_overrun_q;
      if (rx_drop)          rx_overrun_d = 1'b1;
      else if (overrun_clr) rx_overrun_d = 1'b0;
   end

   // Overrun flag register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rx_overrun_q <= 1'b0;
      else      rx_overrun_q <= rx_overrun_d;
   end

endmodule

// File: tb/tb_uart_chan_ctrl.sv
// Self-checking bench for uart_chan_ctrl: queue-based RX model, behavioural
// channel transmitter that logs every frame it is asked to send.
module tb_uart_chan_ctrl;

   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] tx_level;
   logic [3:0] rx_level;
   logic       rx_overrun;
   logic       overrun_clr;

   int checks = 0;
   int errors = 0;

   uart_chan_ctrl_if bus();

   uart_chan_ctrl #(.DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .tx_level    (tx_level),
      .rx_level    (rx_level),
      .rx_overrun  (rx_overrun),
      .overrun_clr (overrun_clr)
   );

   always #5 clk = ~clk;

   // ---------------- channel transmitter model ----------------
   logic [7:0] frames[$];
   logic [7:0] tx_exp[$];
   int         ph = 0;
   int         dcnt = 0;
   int         lcnt = 0;
   int         bdelay = 2;
   int         blen = 10;
   bit         stuck = 0;
   bit         rnd = 0;
   bit         abandon = 0;
   logic [7:0] cur = 8'h00;

   initial begin : chan_model
      bus.chan_tx_busy = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (!rst) abandon = 1'b1;
         case (ph)
            0: begin
               if (rst && bus.chan_tx_start) begin
                  cur = bus.chan_tx_data;
                  frames.push_back(cur);
                  abandon = 1'b0;
                  if (rnd) begin
                     dcnt = int'($urandom_range(1, 3));
                     lcnt = int'($urandom_range(1, 6));
                  end else begin
                     dcnt = bdelay;
                     lcnt = blen;
                  end
                  ph = 1;
               end
            end
            1: begin
               if (!abandon) begin
                  checks++;
                  if (bus.chan_tx_start !== 1'b1 || bus.chan_tx_data !== cur) begin
                     errors++;
                     $display("FAIL start_hold: start=%b data=%h, required start=1 data=%h",
                              bus.chan_tx_start, bus.chan_tx_data, cur);
                  end
               end
               dcnt--;
               if (dcnt <= 0) begin
                  bus.chan_tx_busy = 1'b1;
                  ph = 2;
               end
            end
            default: begin
               if (!abandon) begin
                  checks++;
                  if (bus.chan_tx_start !== 1'b0 || bus.chan_tx_data !== cur) begin
                     errors++;
                     $display("FAIL frame_hold: start=%b data=%h, required start=0 data=%h",
                              bus.chan_tx_start, bus.chan_tx_data, cur);
                  end
               end
               if (!stuck) begin
                  lcnt--;
                  if (lcnt <= 0) begin
                     bus.chan_tx_busy = 1'b0;
                     ph = 0;
                  end
               end
            end
         endcase
      end
   end

   // ---------------- RX reference model ----------------
   logic [7:0] rxq[$];
   bit         rx_ovr = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One clock of RX stimulus; the model applies the same cycle's rules.
   task automatic rx_step(input bit done, input logic [7:0] d, input bit rdy, input bit clr);
      bit pop;
      bit drop;
      bus.chan_rx_done = done;
      bus.chan_rx_data = d;
      bus.m_rx_ready   = rdy;
      overrun_clr      = clr;
      tick();
      bus.chan_rx_done = 1'b0;
      bus.m_rx_ready   = 1'b0;
      overrun_clr      = 1'b0;
      pop  = (rxq.size() > 0) && rdy;
      drop = 1'b0;
      if (pop) void'(rxq.pop_front());
      if (done) begin
         if (rxq.size() < DEPTH) rxq.push_back(d);
         else drop = 1'b1;
      end
      if (drop)     rx_ovr = 1'b1;
      else if (clr) rx_ovr = 1'b0;
   endtask

   task automatic push_tx(input logic [7:0] b, output bit ok);
      ok = 1'b0;
      bus.s_tx_data  = b;
      bus.s_tx_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if (bus.s_tx_ready) begin
            ok = 1'b1;
            tick();
            break;
         end
         tick();
      end
      bus.s_tx_valid = 1'b0;
      if (ok) tx_exp.push_back(b);
   endtask

   task automatic wait_frames(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         if (frames.size() >= tx_exp.size() && ph == 0 && tx_level == 4'd0 &&
             !bus.chan_tx_busy && !bus.chan_tx_start) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      for (int i = 0; i < 6; i++) begin
         bus.s_tx_valid   = 1'($urandom);
         bus.s_tx_data    = 8'($urandom);
         bus.m_rx_ready   = 1'($urandom);
         bus.chan_rx_done = 1'($urandom);
         bus.chan_rx_data = 8'($urandom);
         overrun_clr      = 1'($urandom);
         tick();
         checks++;
         if ({bus.s_tx_ready, bus.m_rx_valid, bus.m_rx_data, bus.chan_tx_start,
              bus.chan_tx_data, tx_level, rx_level, rx_overrun} !== 28'h8000000) begin
            errors++;
            $display("FAIL reset_hold: rdy=%b rv=%b rd=%h st=%b td=%h tl=%0d rl=%0d ov=%b, required 1 0 00 0 00 0 0 0",
                     bus.s_tx_ready, bus.m_rx_valid, bus.m_rx_data, bus.chan_tx_start,
                     bus.chan_tx_data, tx_level, rx_level, rx_overrun);
         end
      end
      bus.s_tx_valid = 1'b0; bus.m_rx_ready = 1'b0; bus.chan_rx_done = 1'b0; overrun_clr = 1'b0;
      rst = 1'b1;
      tick();
      checks++;
      if (bus.s_tx_ready !== 1'b1 || bus.chan_tx_start !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: ready=%b start=%b, required 1 0", bus.s_tx_ready, bus.chan_tx_start);
      end
   endtask

   task automatic test_single_tx();
      bit ok;
      frames.delete(); tx_exp.delete();
      rnd = 0; stuck = 0; bdelay = 2; blen = 10;
      bus.s_tx_data = 8'hA5; bus.s_tx_valid = 1'b1;
      tick();
      bus.s_tx_valid = 1'b0;
      tx_exp.push_back(8'hA5);
      checks++;
      if (bus.chan_tx_start !== 1'b0 || tx_level !== 4'd1) begin
         errors++;
         $display("FAIL single_accept: start=%b level=%0d, required 0 1", bus.chan_tx_start, tx_level);
      end
      tick();
      checks++;
      if (bus.chan_tx_start !== 1'b1 || bus.chan_tx_data !== 8'hA5 || tx_level !== 4'd0) begin
         errors++;
         $display("FAIL single_start: start=%b data=%h level=%0d, required 1 a5 0",
                  bus.chan_tx_start, bus.chan_tx_data, tx_level);
      end
      wait_frames(ok);
      repeat (20) tick();
      checks++;
      if (!ok || frames.size() != 1 || frames[0] !== 8'hA5) begin
         errors++;
         $display("FAIL single_frames: done=%b count=%0d, required done=1 one frame a5", ok, frames.size());
      end
   endtask

   task automatic test_tx_fill();
      bit ok;
      frames.delete(); tx_exp.delete();
      stuck = 1; bdelay = 2; blen = 3;
      for (int i = 0; i < 9; i++) begin
         push_tx(8'(i), ok);
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL fill_push: byte %0d not accepted, required accepted", i);
         end
      end
      bus.s_tx_data = 8'h09; bus.s_tx_valid = 1'b1;
      repeat (4) tick();
      checks++;
      if (bus.s_tx_ready !== 1'b0 || tx_level !== 4'd8 || frames.size() != 1) begin
         errors++;
         $display("FAIL fill_full: ready=%b level=%0d frames=%0d, required 0 8 1",
                  bus.s_tx_ready, tx_level, frames.size());
      end
      bus.s_tx_valid = 1'b0;
      stuck = 0;
      wait_frames(ok);
      checks++;
      if (!ok || frames.size() != 9) begin
         errors++;
         $display("FAIL fill_count: done=%b frames=%0d, required 1 9", ok, frames.size());
      end
      for (int i = 0; i < 9 && i < frames.size(); i++) begin
         checks++;
         if (frames[i] !== 8'(i)) begin
            errors++;
            $display("FAIL fill_order[%0d]: got %h, required %h", i, frames[i], 8'(i));
         end
      end
   endtask

   task automatic test_rx_overrun();
      for (int i = 0; i < 9; i++) begin
         rx_step(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
         if (i == 7) begin
            checks++;
            if (rx_level !== 4'd8 || rx_overrun !== 1'b0) begin
               errors++;
               $display("FAIL ovr_full: level=%0d ovr=%b, required 8 0", rx_level, rx_overrun);
            end
         end
      end
      checks++;
      if (rx_level !== 4'(rxq.size()) || rx_overrun !== rx_ovr || bus.m_rx_data !== rxq[0]) begin
         errors++;
         $display("FAIL ovr_drop: level=%0d ovr=%b head=%h, required %0d %b %h",
                  rx_level, rx_overrun, bus.m_rx_data, rxq.size(), rx_ovr, rxq[0]);
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (bus.m_rx_valid !== 1'b1 || bus.m_rx_data !== 8'h10 + 8'(i)) begin
            errors++;
            $display("FAIL ovr_drain[%0d]: valid=%b data=%h, required 1 %h",
                     i, bus.m_rx_valid, bus.m_rx_data, 8'h10 + 8'(i));
         end
         rx_step(1'b0, 8'h00, 1'b1, 1'b0);
      end
      checks++;
      if (bus.m_rx_valid !== 1'b0 || rx_level !== 4'd0 || rx_overrun !== 1'b1) begin
         errors++;
         $display("FAIL ovr_empty: valid=%b level=%0d ovr=%b, required 0 0 1", bus.m_rx_valid, rx_level, rx_overrun);
      end
      rx_step(1'b0, 8'h00, 1'b0, 1'b1);
      checks++;
      if (rx_overrun !== 1'b0) begin
         errors++;
         $display("FAIL ovr_clear: ovr=%b, required 0", rx_overrun);
      end
   endtask

   task automatic test_rx_corner();
      for (int i = 0; i < 8; i++) rx_step(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
      rx_step(1'b1, 8'h28, 1'b1, 1'b0);
      checks++;
      if (rx_level !== 4'd8 || rx_overrun !== 1'b0 || bus.m_rx_data !== 8'h21) begin
         errors++;
         $display("FAIL corner_pushpop: level=%0d ovr=%b head=%h, required 8 0 21", rx_level, rx_overrun, bus.m_rx_data);
      end
      rx_step(1'b1, 8'h29, 1'b0, 1'b0);
      rx_step(1'b1, 8'h2A, 1'b0, 1'b1);
      checks++;
      if (rx_overrun !== 1'b1) begin
         errors++;
         $display("FAIL corner_setwins1: ovr=%b, required 1", rx_overrun);
      end
      rx_step(1'b0, 8'h00, 1'b0, 1'b1);
      checks++;
      if (rx_overrun !== 1'b0) begin
         errors++;
         $display("FAIL corner_clear: ovr=%b, required 0", rx_overrun);
      end
      rx_step(1'b1, 8'h2B, 1'b0, 1'b1);
      checks++;
      if (rx_overrun !== 1'b1 || rx_level !== 4'd8) begin
         errors++;
         $display("FAIL corner_setwins0: ovr=%b level=%0d, required 1 8", rx_overrun, rx_level);
      end
      while (rxq.size() > 0) begin
         checks++;
         if (bus.m_rx_valid !== 1'b1 || bus.m_rx_data !== rxq[0]) begin
            errors++;
            $display("FAIL corner_drain: valid=%b data=%h, required 1 %h", bus.m_rx_valid, bus.m_rx_data, rxq[0]);
         end
         rx_step(1'b0, 8'h00, 1'b1, 1'b1);
      end
   endtask

   task automatic test_midframe_reset();
      bit ok;
      frames.delete(); tx_exp.delete();
      rnd = 0; stuck = 0; bdelay = 6; blen = 10;
      rx_step(1'b1, 8'h5A, 1'b0, 1'b0);
      rx_step(1'b1, 8'h5B, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) push_tx(8'h31 + 8'(i), ok);
      checks++;
      if (bus.chan_tx_start !== 1'b1 || tx_level !== 4'd3 || rx_level !== 4'd2) begin
         errors++;
         $display("FAIL mid_setup: start=%b txl=%0d rxl=%0d, required 1 3 2", bus.chan_tx_start, tx_level, rx_level);
      end
      rst = 1'b0;
      #1;
      checks++;
      if ({bus.s_tx_ready, bus.m_rx_valid, bus.m_rx_data, bus.chan_tx_start,
           bus.chan_tx_data, tx_level, rx_level, rx_overrun} !== 28'h8000000) begin
         errors++;
         $display("FAIL mid_clear: rdy=%b rv=%b rd=%h st=%b td=%h tl=%0d rl=%0d ov=%b, required 1 0 00 0 00 0 0 0",
                  bus.s_tx_ready, bus.m_rx_valid, bus.m_rx_data, bus.chan_tx_start,
                  bus.chan_tx_data, tx_level, rx_level, rx_overrun);
      end
      rxq.delete(); rx_ovr = 0; tx_exp.delete();
      tick(); tick();
      rst = 1'b1;
      for (int i = 0; i < 30; i++) begin
         tick();
         checks++;
         if (bus.chan_tx_start !== 1'b0 || bus.chan_tx_data !== 8'h00 || tx_level !== 4'd0) begin
            errors++;
            $display("FAIL mid_spurious: start=%b data=%h level=%0d, required 0 00 0",
                     bus.chan_tx_start, bus.chan_tx_data, tx_level);
         end
      end
      frames.delete();
   endtask

   task automatic test_random();
      bit ok;
      bit v;
      frames.delete(); tx_exp.delete();
      rnd = 1; stuck = 0;
      for (int i = 0; i < 400; i++) begin
         v = ($urandom_range(0, 1) == 0);
         bus.s_tx_valid = v;
         bus.s_tx_data  = 8'($urandom);
         if (v && bus.s_tx_ready) tx_exp.push_back(bus.s_tx_data);
         rx_step($urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 1) == 0,
                 $urandom_range(0, 9) == 0);
         checks++;
         if (bus.m_rx_valid !== (rxq.size() > 0) || rx_level !== 4'(rxq.size()) ||
             rx_overrun !== rx_ovr || (rxq.size() > 0 && bus.m_rx_data !== rxq[0])) begin
            errors++;
            $display("FAIL rand_rx[%0d]: valid=%b level=%0d ovr=%b data=%h, required level=%0d ovr=%b",
                     i, bus.m_rx_valid, rx_level, rx_overrun, bus.m_rx_data, rxq.size(), rx_ovr);
         end
      end
      bus.s_tx_valid = 1'b0;
      wait_frames(ok);
      checks++;
      if (!ok || frames.size() != tx_exp.size()) begin
         errors++;
         $display("FAIL rand_tx_count: done=%b frames=%0d, required 1 %0d", ok, frames.size(), tx_exp.size());
      end
      for (int i = 0; i < tx_exp.size() && i < frames.size(); i++) begin
         checks++;
         if (frames[i] !== tx_exp[i]) begin
            errors++;
            $display("FAIL rand_tx_order[%0d]: got %h, required %h", i, frames[i], tx_exp[i]);
         end
      end
   endtask

   initial begin
      rst = 1'b0;
      bus.s_tx_valid = 1'b0; bus.s_tx_data = 8'h00; bus.m_rx_ready = 1'b0;
      bus.chan_rx_done = 1'b0; bus.chan_rx_data = 8'h00; overrun_clr = 1'b0;
      test_reset();
      test_single_tx();
      test_tx_fill();
      test_rx_overrun();
      test_rx_corner();
      test_midframe_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "time limit");
   end

endmodule
